pkt_key_arbiter: RTL and testbench
==================================

# pkt_key_arbiter

Arbitrates shared access to the PKT key-location lookup among several on-chip crypto requesters (AES, SHA, HMAC engines). It accepts one key-index request at a time using round-robin selection and enforces a per-requester key-access policy. It sequences the PKT handshake, captures the returned key location, and routes it back to the winning requester. The block sits between the crypto engines and the `pkt` instance, replacing direct register-driven `req`/`key_index` control.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `NUM_KEYS`, 8: number of valid key indices; legal indices are 0..NUM_KEYS-1.
- `LOOKUP_LAT`, 2: cycles from PKT request to valid `pkt_loc_i` (≥1).
- `ACCESS_MASK`, all ones, width NUM_REQ*NUM_KEYS: bit `r*NUM_KEYS+k` set means requester r may use key k.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_index_i`  in  NUM_REQ*32  per-requester key index; requester r occupies bits [32r+31:32r].
- `req_ready_o`  out  NUM_REQ  one-hot accept pulse.
- `rsp_valid_o`  out  NUM_REQ  one-hot single-cycle response pulse.
- `rsp_loc_o`  out  32  key location; meaningful only while any `rsp_valid_o` bit is set.
- `rsp_err_o`  out  1  access denied or index out of range; qualified by `rsp_valid_o`.
- `pkt_req_o`  out  1  request to PKT.
- `pkt_key_index_o`  out  32  key index to PKT.
- `pkt_loc_i`  in  32  key location from PKT.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid_i` bit is set, the round-robin picker selects a winner w, searching upward from `rr_ptr` with wrap.
  - `req_ready_o[w]` is asserted combinationally in the same cycle.
  - `req_index_i[w]` and w are latched.
  - Next state is ISSUE if the request is legal, otherwise RESP with the error flag set.
- **Legality:** the index must be < NUM_KEYS (full 32-bit compare) and `ACCESS_MASK` bit `w*NUM_KEYS+index` must be 1.
- **ISSUE:** `pkt_req_o`=1 and `pkt_key_index_o` = latched index. Next state is WAIT, with the counter loaded to LOOKUP_LAT-1.
- **WAIT**
  - `pkt_req_o` stays 1 and the index stays stable.
  - When the counter reaches 0, `pkt_loc_i` is captured and the next state is RESP. Otherwise the counter decrements.
- **RESP**
  - `rsp_valid_o[w]`=1 for exactly one cycle, with `rsp_loc_o` = captured location (0 on error) and `rsp_err_o` = error flag.
  - `pkt_req_o`=0.
  - `rr_ptr` ← (w+1) mod NUM_REQ.
  - Next state is IDLE.
- Denied or illegal requests never assert `pkt_req_o`, and they still advance `rr_ptr`.
- Responses have no backpressure. Requesters must accept the response pulse.
- Requesters hold `req_valid_i` and the index stable until they see `req_ready_o`. Deasserting `req_valid_i` before `req_ready_o` is legal and simply withdraws the request.
- Outside RESP, `rsp_loc_o` and `rsp_err_o` are 0. Outside ISSUE/WAIT, `pkt_key_index_o` is 0.

## Timing

- **Reset** (`rst_i` high at a clock edge):
  - State returns to IDLE.
  - `rr_ptr`, counter, latched index, winner and error flag are cleared.
  - All outputs are 0 in the following cycle.
  - `req_ready_o` is held 0 while `rst_i` is high.
  - Reset mid-operation aborts the transaction with no response.
- **Legal request accepted in cycle T:**
  - ISSUE at T+1.
  - WAIT from T+2 to T+1+LOOKUP_LAT.
  - `pkt_loc_i` sampled at T+1+LOOKUP_LAT.
  - `rsp_valid_o` at T+2+LOOKUP_LAT.
  - Total `pkt_req_o` high time is LOOKUP_LAT+1 cycles.
- **Illegal request accepted in cycle T:** response at T+1.
- **Next acceptance:** earliest in the cycle after RESP. Legal-request throughput is one per LOOKUP_LAT+3 cycles.
- **Simultaneous requests:** exactly one `req_ready_o` bit fires per acceptance. Under continuous contention, no requester waits more than NUM_REQ-1 transactions.
- **Requests arriving during busy:** ignored (no `req_ready_o`) until IDLE.

## Structure

- Package `pkt_arb_pkg` holds:
  - the state enum `pkt_arb_state_e` (IDLE, ISSUE, WAIT, RESP);
  - `PKT_IDX_W`=32 and `PKT_LOC_W`=32.
- Sub-module `pkt_rr_picker`:
  - parameter NUM_REQ;
  - inputs: request vector, `rr_ptr`;
  - outputs: one-hot grant, binary index, any-valid;
  - purely combinational.
- `rr_ptr` and all FSM registers live in `pkt_key_arbiter`.

## Test plan

- **Single legal lookup:** reset, then requester 1 with index 3 and LOOKUP_LAT=2, with the PKT model returning 0x0000_1300.
  - Expect `req_ready_o`=4'b0010 at T, `pkt_req_o` high T+1..T+3 with index 3, and `rsp_valid_o`=4'b0010 with `rsp_loc_o`=0x0000_1300 and err=0 at T+4.
- **Out-of-range index:** requester 0 with index 8 (NUM_KEYS=8).
  - Expect a response at T+1 with err=1, loc=0, and `pkt_req_o` never high.
- **Policy denial:** ACCESS_MASK clears bit (2*8+5), then requester 2 requests index 5.
  - Expect err=1, no PKT request, and `rr_ptr`=3 afterwards.
- **Round-robin fairness:** all four requesters held valid for 8 transactions from reset.
  - Expect grant order 0,1,2,3,0,1,2,3 with each response routed to the matching bit only.
- **Reset mid-WAIT:** `rst_i` asserted at T+2 of a legal lookup.
  - Expect no `rsp_valid_o`, all outputs 0 the next cycle, and the next request accepted normally with `rr_ptr`=0.
- **Withdrawn request while busy:** requester 3 pulses valid only during WAIT of another transaction.
  - Expect no `req_ready_o[3]` and no response to requester 3.

Source files
------------

// File: rtl/pkt_arb_pkg.sv
// pkt_arb_pkg -- shared types and widths for the PKT key-lookup arbiter.
// Rev 1.0
`default_nettype none

package pkt_arb_pkg;

  localparam int PKT_IDX_W = 32;
  localparam int PKT_LOC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } pkt_arb_state_e;

endpackage

`default_nettype wire

// File: rtl/pkt_rr_picker.sv
// pkt_rr_picker -- combinational round-robin picker, searches upward from ptr_i with wrap.
// Rev 1.0
`default_nettype none

module pkt_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!found && req_i[r] && (r == (int'(ptr_i) + off) % NUM_REQ)) begin
          found    = 1'b1;
          gnt_o[r] = 1'b1;
          idx_o    = PTR_W'(r);
        end
      end
    end
  end

  assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/pkt_key_arbiter.sv
// pkt_key_arbiter -- round-robin arbiter sequencing PKT key-location lookups with a per-requester key policy.
// Rev 1.0
`default_nettype none

module pkt_key_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int                       NUM_REQ     = 4,
  parameter int                       NUM_KEYS    = 8,
  parameter int                       LOOKUP_LAT  = 2,
  parameter logic [NUM_REQ*NUM_KEYS-1:0] ACCESS_MASK = '1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*PKT_IDX_W-1:0] req_index_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [PKT_LOC_W-1:0]         rsp_loc_o,
  output logic                         rsp_err_o,
  output logic                         pkt_req_o,
  output logic [PKT_IDX_W-1:0]         pkt_key_index_o,
  input  logic [PKT_LOC_W-1:0]         pkt_loc_i,
  output logic                         busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

  pkt_arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      win_q, win_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PKT_IDX_W-1:0]  index_q, index_d;
  logic [PKT_LOC_W-1:0]  loc_q, loc_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [PKT_IDX_W-1:0]  sel_index;
  logic                  sel_legal;

  pkt_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Enumerating every (requester, key) pair gives the full 32-bit range
  // compare for free: an index >= NUM_KEYS never matches and stays illegal.
  always_comb begin
    sel_index = '0;
    sel_legal = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (pick_gnt[r]) sel_index = req_index_i[r*PKT_IDX_W +: PKT_IDX_W];
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (pick_gnt[r] && (sel_index == PKT_IDX_W'(k))) sel_legal = ACCESS_MASK[r*NUM_KEYS+k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      index_q  <= '0;
      loc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      index_q  <= index_d;
      loc_q    <= loc_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    index_d  = index_q;
    loc_d    = loc_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          index_d = sel_index;
          win_d   = pick_idx;
          err_d   = ~sel_legal;
          loc_d   = '0;
          state_d = sel_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(LOOKUP_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          loc_d   = pkt_loc_i;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (state_q == ST_IDLE && !rst_i) req_ready_o = pick_gnt;
    for (int r = 0; r < NUM_REQ; r++) begin
      rsp_valid_o[r] = (state_q == ST_RESP) && (win_q == PTR_W'(r));
    end
  end

  assign pkt_req_o       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign pkt_key_index_o = pkt_req_o ? index_q : '0;
  assign rsp_loc_o       = (state_q == ST_RESP) ? loc_q : '0;
  assign rsp_err_o       = (state_q == ST_RESP) && err_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pkt_key_arbiter.sv
// tb_pkt_key_arbiter -- directed self-checking bench for pkt_key_arbiter.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_pkt_key_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int NUM_KEYS   = 8;
  localparam int LOOKUP_LAT = 2;
  localparam logic [31:0] MASK = ~(32'h1 << (2*8+5));

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [127:0]  req_index;
  logic [3:0]    req_ready;
  logic [3:0]    rsp_valid;
  logic [31:0]   rsp_loc;
  logic          rsp_err;
  logic          pkt_req;
  logic [31:0]   pkt_key_index;
  logic [31:0]   pkt_loc;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;
  int pkt_cnt = 0;

  pkt_key_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .NUM_KEYS    (NUM_KEYS),
    .LOOKUP_LAT  (LOOKUP_LAT),
    .ACCESS_MASK (MASK)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_index_i     (req_index),
    .req_ready_o     (req_ready),
    .rsp_valid_o     (rsp_valid),
    .rsp_loc_o       (rsp_loc),
    .rsp_err_o       (rsp_err),
    .pkt_req_o       (pkt_req),
    .pkt_key_index_o (pkt_key_index),
    .pkt_loc_i       (pkt_loc),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  // PKT model: location is only valid on the LOOKUP_LAT-th cycle after the request rises.
  always @(posedge clk) pkt_cnt <= pkt_req ? pkt_cnt + 1 : 0;
  assign pkt_loc = (pkt_req && pkt_cnt == LOOKUP_LAT) ? (32'h0000_1000 | (pkt_key_index << 8))
                                                      : 32'hBAD0_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_idx(input int r, input logic [31:0] v);
    req_index[r*32 +: 32] = v;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_index = '0;
    tick();
    #1;
    chk("ready_in_reset", {28'h0, req_ready}, 32'h0);
    tick();
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_pkt_req", {31'h0, pkt_req}, 32'h0);
    chk("reset_rsp_valid", {28'h0, rsp_valid}, 32'h0);
    rst       = 1'b0;
    req_valid = 4'b0000;
    tick();

    // Single legal lookup: requester 1, index 3.
    req_valid = 4'b0010;
    set_idx(1, 32'd3);
    #1;
    chk("t1_ready", {28'h0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t1_issue_req", {31'h0, pkt_req}, 32'h1);
    chk("t1_issue_idx", pkt_key_index, 32'd3);
    tick();
    chk("t1_wait1_req", {31'h0, pkt_req}, 32'h1);
    chk("t1_wait1_idx", pkt_key_index, 32'd3);
    tick();
    chk("t1_wait2_req", {31'h0, pkt_req}, 32'h1);
    chk("t1_wait2_rsp", {28'h0, rsp_valid}, 32'h0);
    tick();
    chk("t1_rsp_valid", {28'h0, rsp_valid}, 32'h2);
    chk("t1_rsp_loc", rsp_loc, 32'h0000_1300);
    chk("t1_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("t1_rsp_pkt_req", {31'h0, pkt_req}, 32'h0);
    tick();
    chk("t1_idle_rsp", {28'h0, rsp_valid}, 32'h0);
    chk("t1_idle_busy", {31'h0, busy}, 32'h0);
    chk("t1_idle_loc", rsp_loc, 32'h0);

    // Out-of-range index 8 from requester 0 (rr_ptr now 2, wraps to 0).
    req_valid = 4'b0001;
    set_idx(0, 32'd8);
    #1;
    chk("t2_ready", {28'h0, req_ready}, 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t2_rsp_valid", {28'h0, rsp_valid}, 32'h1);
    chk("t2_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("t2_rsp_loc", rsp_loc, 32'h0);
    chk("t2_pkt_req", {31'h0, pkt_req}, 32'h0);
    tick();
    chk("t2_idle_err", {31'h0, rsp_err}, 32'h0);

    // Index whose low bits alias key 3 but upper bits are set: still out of range.
    req_valid = 4'b0010;
    set_idx(1, 32'h0001_0003);
    #1;
    chk("t2b_ready", {28'h0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t2b_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("t2b_pkt_req", {31'h0, pkt_req}, 32'h0);
    tick();

    // Policy denial: requester 2 may not use key 5 (rr_ptr now 2).
    req_valid = 4'b0100;
    set_idx(2, 32'd5);
    #1;
    chk("t3_ready", {28'h0, req_ready}, 32'h4);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t3_rsp_valid", {28'h0, rsp_valid}, 32'h4);
    chk("t3_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("t3_pkt_req", {31'h0, pkt_req}, 32'h0);
    tick();
    // rr_ptr must now be 3: with everyone valid requester 3 wins.
    req_valid = 4'b1111;
    set_idx(0, 32'd1);
    set_idx(1, 32'd2);
    set_idx(2, 32'd4);
    set_idx(3, 32'd6);
    #1;
    chk("t3_ptr_after_deny", {28'h0, req_ready}, 32'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    chk("t3_r3_rsp_valid", {28'h0, rsp_valid}, 32'h8);
    chk("t3_r3_rsp_loc", rsp_loc, 32'h0000_1600);
    tick();

    // Round-robin fairness from reset.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr%0d_ready", i), {28'h0, req_ready}, 32'h1 << (i % 4));
      tick();
      tick();
      chk($sformatf("rr%0d_busy_ready", i), {28'h0, req_ready}, 32'h0);
      tick();
      tick();
      chk($sformatf("rr%0d_rsp_valid", i), {28'h0, rsp_valid}, 32'h1 << (i % 4));
      chk($sformatf("rr%0d_rsp_loc", i), rsp_loc,
          (i % 4 == 0) ? 32'h1100 : (i % 4 == 1) ? 32'h1200 : (i % 4 == 2) ? 32'h1400 : 32'h1600);
      if (i == 7) req_valid = 4'b0000;
      tick();
    end
    chk("rr_done_busy", {31'h0, busy}, 32'h0);

    // Move rr_ptr to 2 with an illegal request, then abort a lookup by reset.
    req_valid = 4'b0010;
    set_idx(1, 32'd9);
    tick();
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b0100;
    set_idx(2, 32'd4);
    #1;
    chk("t5_ready", {28'h0, req_ready}, 32'h4);
    tick();
    req_valid = 4'b0000;
    tick();
    rst = 1'b1;
    #1;
    chk("t5_wait_pkt_req", {31'h0, pkt_req}, 32'h1);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_post_rst_pkt_req", {31'h0, pkt_req}, 32'h0);
    chk("t5_post_rst_idx", pkt_key_index, 32'h0);
    chk("t5_post_rst_rsp", {28'h0, rsp_valid}, 32'h0);
    chk("t5_post_rst_busy", {31'h0, busy}, 32'h0);
    tick();
    chk("t5_no_rsp", {28'h0, rsp_valid}, 32'h0);
    req_valid = 4'b1111;
    #1;
    chk("t5_ptr_zero", {28'h0, req_ready}, 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    chk("t5_rsp_valid", {28'h0, rsp_valid}, 32'h1);
    chk("t5_rsp_loc", rsp_loc, 32'h0000_1100);
    tick();

    // Requester 3 pulses valid only during WAIT of requester 1's lookup.
    req_valid = 4'b0010;
    set_idx(1, 32'd3);
    set_idx(3, 32'd0);
    #1;
    chk("t6_ready", {28'h0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b1000;
    #1;
    chk("t6_wait1_ready", {28'h0, req_ready}, 32'h0);
    tick();
    chk("t6_wait2_ready", {28'h0, req_ready}, 32'h0);
    req_valid = 4'b0000;
    tick();
    chk("t6_rsp_valid", {28'h0, rsp_valid}, 32'h2);
    chk("t6_rsp_loc", rsp_loc, 32'h0000_1300);
    tick();
    chk("t6_idle_rsp", {28'h0, rsp_valid}, 32'h0);
    chk("t6_idle_busy", {31'h0, busy}, 32'h0);
    tick();
    chk("t6_no_r3_rsp", {28'h0, rsp_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
